// File: rtl/alu_psr_pkg.sv
// Shared opcode encodings, PSR bit positions and FSM states for the ALU.
package alu_psr_pkg;
    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_NOT  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_ADDC = 4'h6;
    localparam logic [3:0] OP_SUBC = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_SAR  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, low half kept.
module alu_seq_mul #(
    parameter int DATA_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] a_i,
    input  logic [DATA_LENGTH-1:0] b_i,
    output logic                   done_o,
    output logic [DATA_LENGTH-1:0] p_o
);
    localparam int CW = $clog2(DATA_LENGTH) + 1;

    logic [DATA_LENGTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            cnt_d    = CW'(DATA_LENGTH);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Asserted during the cycle whose closing edge performs the final step.
    assign done_o = (cnt_q == CW'(1));
    assign p_o    = acc_q;
endmodule

// File: rtl/alu_psr_seq.sv
// Registered ALU with status register, valid/ready handshake and multi-cycle MUL.
module alu_psr_seq
    import alu_psr_pkg::*;
#(
    parameter int DATA_LENGTH   = 16,
    parameter int FUNCTION_BITS = 4,
    parameter int PSR_WIDTH     = 16,
    parameter int MUL_ENABLE    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     I_valid,
    output logic                     O_ready,
    input  logic [FUNCTION_BITS-1:0] I_sel,
    input  logic                     I_cmp,
    input  logic [DATA_LENGTH-1:0]   I_a,
    input  logic [DATA_LENGTH-1:0]   I_b,
    output logic                     O_valid,
    output logic [DATA_LENGTH-1:0]   O_s,
    output logic                     O_wr,
    output logic [PSR_WIDTH-1:0]     O_psr
);
    localparam int DL = DATA_LENGTH;
    localparam int SW = $clog2(DATA_LENGTH);
    localparam logic [FUNCTION_BITS-1:0] S_SUB  = FUNCTION_BITS'(OP_SUB);
    localparam logic [FUNCTION_BITS-1:0] S_SUBC = FUNCTION_BITS'(OP_SUBC);
    localparam logic [FUNCTION_BITS-1:0] S_ADDC = FUNCTION_BITS'(OP_ADDC);
    localparam logic [FUNCTION_BITS-1:0] S_MUL  = FUNCTION_BITS'(OP_MUL);

    state_e               state_q, state_d;
    logic [DL-1:0]        s_q, s_d;
    logic [PSR_WIDTH-1:0] psr_q, psr_d;
    logic                 wr_q, wr_d, valid_q, valid_d;

    logic [DL-1:0]        b_eff, alu_s, mul_p;
    logic [DL:0]          sum, shl, shr, sar;
    logic [SW-1:0]        amt;
    logic [PSR_WIDTH-1:0] alu_psr;
    logic                 cin, c_msb, alu_wr, sel_mul, mul_start, mul_done;

    assign amt     = I_b[SW-1:0];
    assign sel_mul = (MUL_ENABLE != 0) && (I_sel == S_MUL);

    always_comb begin
        b_eff = (I_sel == S_SUB || I_sel == S_SUBC) ? ~I_b : I_b;
        case (I_sel)
            S_SUB:   cin = 1'b1;
            S_ADDC:  cin = psr_q[PSR_C];
            S_SUBC:  cin = ~psr_q[PSR_C];
            default: cin = 1'b0;
        endcase
        sum   = {1'b0, I_a} + {1'b0, b_eff} + {{DL{1'b0}}, cin};
        c_msb = I_a[DL-1] ^ b_eff[DL-1] ^ sum[DL-1];
        // Extra bit on the outgoing side captures the last bit shifted out.
        shl   = {1'b0, I_a} << amt;
        shr   = {I_a, 1'b0} >> amt;
        sar   = $signed({I_a, 1'b0}) >>> amt;

        alu_s   = s_q;
        alu_wr  = 1'b1;
        alu_psr = psr_q;
        case (I_sel)
            FUNCTION_BITS'(OP_AND): alu_s = I_a & I_b;
            FUNCTION_BITS'(OP_OR):  alu_s = I_a | I_b;
            FUNCTION_BITS'(OP_XOR): alu_s = I_a ^ I_b;
            FUNCTION_BITS'(OP_NOT): alu_s = ~I_a;
            FUNCTION_BITS'(OP_ADD), FUNCTION_BITS'(OP_ADDC): begin
                alu_s          = sum[DL-1:0];
                alu_psr[PSR_C] = sum[DL];
                alu_psr[PSR_F] = c_msb ^ sum[DL];
            end
            FUNCTION_BITS'(OP_SUB), FUNCTION_BITS'(OP_SUBC): begin
                if (I_cmp && I_sel == S_SUB) begin
                    alu_wr         = 1'b0;
                    alu_psr[PSR_L] = I_a < I_b;
                    alu_psr[PSR_Z] = I_a == I_b;
                    alu_psr[PSR_N] = $signed(I_a) < $signed(I_b);
                end else begin
                    alu_s          = sum[DL-1:0];
                    alu_psr[PSR_C] = ~sum[DL];
                    alu_psr[PSR_F] = c_msb ^ sum[DL];
                end
            end
            FUNCTION_BITS'(OP_SHL): begin
                alu_s = shl[DL-1:0];
                if (amt != '0) alu_psr[PSR_C] = shl[DL];
            end
            FUNCTION_BITS'(OP_SHR): begin
                alu_s = shr[DL:1];
                if (amt != '0) alu_psr[PSR_C] = shr[0];
            end
            FUNCTION_BITS'(OP_SAR): begin
                alu_s = sar[DL:1];
                if (amt != '0) alu_psr[PSR_C] = sar[0];
            end
            default: alu_wr = 1'b0;
        endcase
    end

    generate
        if (MUL_ENABLE != 0) begin : g_mul
            alu_seq_mul #(.DATA_LENGTH(DATA_LENGTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start_i (mul_start),
                .a_i     (I_a),
                .b_i     (I_b),
                .done_o  (mul_done),
                .p_o     (mul_p)
            );
        end else begin : g_nomul
            assign mul_done = 1'b0;
            assign mul_p    = '0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        psr_d     = psr_q;
        wr_d      = wr_q;
        valid_d   = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_valid) begin
                    if (sel_mul) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        valid_d = 1'b1;
                        wr_d    = alu_wr;
                        s_d     = alu_s;
                        psr_d   = alu_psr;
                    end
                end
            end
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DONE: begin
                valid_d = 1'b1;
                wr_d    = 1'b1;
                s_d     = mul_p;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            psr_q   <= '0;
            wr_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            psr_q   <= psr_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
        end
    end

    assign O_ready = (state_q == ST_IDLE);
    assign O_valid = valid_q;
    assign O_s     = s_q;
    assign O_wr    = wr_q;
    assign O_psr   = psr_q;
endmodule

// File: tb/tb_alu_psr_seq.sv
// Directed bench for alu_psr_seq: reference model feeds a scoreboard queue.
module tb_alu_psr_seq;
    logic        clk, rst_n, I_valid, I_cmp, O_ready, O_valid, O_wr;
    logic [3:0]  I_sel;
    logic [15:0] I_a, I_b, O_s, O_psr;

    typedef struct {
        logic [15:0] s;
        logic        wr;
        logic [15:0] psr;
        string       tag;
    } exp_t;

    exp_t        q[$];
    logic [15:0] ref_s, ref_psr;
    int          checks, errors;

    alu_psr_seq dut (
        .clk(clk), .rst_n(rst_n), .I_valid(I_valid), .O_ready(O_ready),
        .I_sel(I_sel), .I_cmp(I_cmp), .I_a(I_a), .I_b(I_b),
        .O_valid(O_valid), .O_s(O_s), .O_wr(O_wr), .O_psr(O_psr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic bit ovf(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Independent reference: integer arithmetic, flags from signed range checks.
    task automatic push_exp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic cmp, input string tag);
        int sa, sb, ci, r, n;
        logic [15:0] s, p;
        logic wr;
        exp_t e;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = int'(ref_psr[0]);
        n  = int'(b[3:0]);
        s  = ref_s;
        p  = ref_psr;
        wr = 1'b1;
        case (op)
            4'h0: s = a & b;
            4'h1: s = a | b;
            4'h2: s = a ^ b;
            4'h3: s = ~a;
            4'h4: begin r = int'(a) + int'(b); s = r[15:0]; p[0] = r[16]; p[5] = ovf(sa + sb); end
            4'h5: begin
                if (cmp) begin
                    wr = 1'b0; p[2] = a < b; p[6] = a == b; p[7] = sa < sb;
                end else begin
                    r = int'(a) - int'(b); s = r[15:0]; p[0] = a < b; p[5] = ovf(sa - sb);
                end
            end
            4'h6: begin r = int'(a) + int'(b) + ci; s = r[15:0]; p[0] = r[16]; p[5] = ovf(sa + sb + ci); end
            4'h7: begin r = int'(a) - int'(b) - ci; s = r[15:0]; p[0] = r < 0; p[5] = ovf(sa - sb - ci); end
            4'h8: begin s = a << n; if (n != 0) p[0] = a[16-n]; end
            4'h9: begin s = a >> n; if (n != 0) p[0] = a[n-1]; end
            4'hA: begin r = sa >>> n; s = r[15:0]; if (n != 0) p[0] = a[n-1]; end
            4'hB: begin r = int'(a) * int'(b); s = r[15:0]; end
            default: wr = 1'b0;
        endcase
        ref_s   = s;
        ref_psr = p;
        e.s = s; e.wr = wr; e.psr = p; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cmp, input string tag);
        I_valid = 1'b1; I_sel = op; I_a = a; I_b = b; I_cmp = cmp;
        push_exp(op, a, b, cmp, tag);
        @(posedge clk);
        #1 I_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (O_valid) begin
            chk("unexpected_valid", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk({e.tag, "_s"},   32'(O_s),   32'(e.s));
                chk({e.tag, "_wr"},  32'(O_wr),  32'(e.wr));
                chk({e.tag, "_psr"}, 32'(O_psr), 32'(e.psr));
            end
        end
    end

    initial begin
        checks = 0; errors = 0; ref_s = '0; ref_psr = '0;
        rst_n = 1'b0; I_valid = 1'b0; I_sel = '0; I_cmp = 1'b0; I_a = '0; I_b = '0;
        #3;
        chk("rst_s", 32'(O_s), 32'h0);
        chk("rst_psr", 32'(O_psr), 32'h0);
        chk("rst_valid", 32'(O_valid), 32'h0);
        chk("rst_wr", 32'(O_wr), 32'h0);
        chk("rst_ready", 32'(O_ready), 32'h1);
        @(negedge clk) rst_n = 1'b1;

        issue(4'h4, 16'hFFFF, 16'h0001, 1'b0, "add_wrap");
        @(negedge clk) chk("add_latency", 32'(O_valid), 32'h1);
        @(negedge clk) chk("valid_pulse", 32'(O_valid), 32'h0);

        issue(4'h4, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
        issue(4'h6, 16'h0000, 16'h0000, 1'b0, "addc_c0");
        issue(4'h4, 16'hFFFF, 16'h0001, 1'b0, "add_c1");
        issue(4'h6, 16'h0000, 16'h0000, 1'b0, "addc_c1");
        issue(4'h4, 16'hFFFF, 16'h0002, 1'b0, "add_setc");
        issue(4'h5, 16'h0003, 16'h8000, 1'b1, "cmp_lt");
        issue(4'h5, 16'h0005, 16'h0005, 1'b1, "cmp_eq");
        issue(4'h5, 16'h8000, 16'h0001, 1'b1, "cmp_neg");
        issue(4'h5, 16'h0003, 16'h0005, 1'b0, "sub_borrow");
        issue(4'h7, 16'h0005, 16'h0003, 1'b1, "subc_chain");
        issue(4'h7, 16'h8000, 16'h0001, 1'b0, "subc_ovf");
        issue(4'hA, 16'h8001, 16'h0011, 1'b0, "sar_1");
        issue(4'h8, 16'h1234, 16'h0010, 1'b0, "shl_0");
        issue(4'h9, 16'h8001, 16'h000F, 1'b0, "shr_15");
        issue(4'h8, 16'h8001, 16'h0001, 1'b0, "shl_1");
        issue(4'h0, 16'hF0F0, 16'h3C3C, 1'b0, "and");
        issue(4'h1, 16'hF0F0, 16'h3C3C, 1'b0, "or");
        issue(4'h2, 16'hF0F0, 16'h3C3C, 1'b0, "xor");
        issue(4'h3, 16'hF0F0, 16'h3C3C, 1'b0, "not");
        issue(4'hC, 16'h1111, 16'h2222, 1'b0, "illegal");
        @(negedge clk);

        issue(4'hB, 16'h0123, 16'h0010, 1'b0, "mul");
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk("mul_busy_ready", 32'(O_ready), 32'h0);
            chk("mul_busy_valid", 32'(O_valid), 32'h0);
            if (i >= 1 && i < 9) begin
                I_valid = 1'b1; I_sel = 4'h4; I_a = 16'h0101; I_b = 16'h0202;
            end else begin
                I_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("mul_done_ready", 32'(O_ready), 32'h1);
        chk("mul_done_valid", 32'(O_valid), 32'h1);
        @(negedge clk);

        issue(4'hB, 16'h0123, 16'h0010, 1'b0, "mul_abort");
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        ref_s = '0; ref_psr = '0;
        #1;
        chk("abort_psr", 32'(O_psr), 32'h0);
        chk("abort_s", 32'(O_s), 32'h0);
        chk("abort_ready", 32'(O_ready), 32'h1);
        chk("abort_valid", 32'(O_valid), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(O_valid), 32'h0);
        end
        issue(4'h4, 16'h0001, 16'h0002, 1'b0, "add_after_abort");
        @(negedge clk) chk("post_abort_latency", 32'(O_valid), 32'h1);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drain", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
